// File: rtl/base_crdt_slice.sv
// Credit-throttled two-entry skid-buffer stage between an upstream and a downstream valid/ready stream.
// Optional macro BASE_CRDT_SLICE_STALL_CNT_EN adds a saturating credit-stall cycle counter on o_stall_cnt.
module base_crdt_slice #(
    parameter int width   = 8,
    parameter int credits = 4,
    parameter int cwidth  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [width-1:0]  i_d,
    output logic              o_v,
    input  logic              o_r,
    output logic [width-1:0]  o_d,
    input  logic              crd_ret,
    output logic [cwidth-1:0] crd_avail,
    output logic              crd_err
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt
`endif
);

    localparam logic [cwidth-1:0] CrdMax = cwidth'(credits);

    logic [width-1:0]  entry_q [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [cwidth-1:0] crd_q, crd_d;
    logic              err_q, err_d;
    logic              push, pop;

    // Handshake outputs come straight from registers so ready never depends on downstream signals.
    assign i_r       = (count_q != 2'd2);
    assign o_v       = (count_q != 2'd0) && (crd_q != '0);
    assign o_d       = entry_q[head_q];
    assign crd_avail = crd_q;
    assign crd_err   = err_q;
    assign push      = i_v && i_r;
    assign pop       = o_v && o_r;

    always_comb begin
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        crd_d = crd_q;
        err_d = err_q;
        // A return that would push the pool past its size is dropped and flagged.
        if (pop && !crd_ret) begin
            crd_d = crd_q - cwidth'(1);
        end else if (crd_ret && !pop) begin
            if (crd_q == CrdMax) begin
                err_d = 1'b1;
            end else begin
                crd_d = crd_q + cwidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            crd_q   <= CrdMax;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            crd_q   <= crd_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= i_d;
        end
    end

`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((count_q != 2'd0) && (crd_q == '0) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_base_crdt_slice.sv
// Self-checking bench for base_crdt_slice: directed scenarios plus a randomized phase against a queue-based model.
// Define BASE_CRDT_SLICE_STALL_CNT_EN for both bench and RTL to also check the stall counter.
module tb_base_crdt_slice;

    localparam int Credits = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_v = 1'b0;
    logic       i_r;
    logic [7:0] i_d = 8'h00;
    logic       o_v;
    logic       o_r = 1'b0;
    logic [7:0] o_d;
    logic       crd_ret = 1'b0;
    logic [2:0] crd_avail;
    logic       crd_err;
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] stallBase;
`endif

    base_crdt_slice #(.width(8), .credits(Credits), .cwidth(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_d       (i_d),
        .o_v       (o_v),
        .o_r       (o_r),
        .o_d       (o_d),
        .crd_ret   (crd_ret),
        .crd_avail (crd_avail),
        .crd_err   (crd_err)
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of buffered beats, a credit pool and a sticky error bit.
    logic [7:0]  mq[$];
    int          mcrd = Credits;
    bit          merr = 1'b0;
    logic [31:0] mstall = 32'd0;
    bit          lastPop = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [7:0] obsq[$];
    logic [7:0] streamData[5];

    // Records every beat the DUT actually hands downstream, in order.
    always @(posedge clk) begin
        if (!reset && o_v && o_r) begin
            obsq.push_back(o_d);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareModel();
        bit expV;
        expV = (mq.size() != 0) && (mcrd != 0);
        checkOutput("i_r", 32'(i_r), 32'(mq.size() != 2));
        checkOutput("o_v", 32'(o_v), 32'(expV));
        if (expV) begin
            checkOutput("o_d", 32'(o_d), 32'(mq[0]));
        end
        checkOutput("crd_avail", 32'(crd_avail), 32'(mcrd));
        checkOutput("crd_err", 32'(crd_err), 32'(merr));
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
        checkOutput("stall_cnt", o_stall_cnt, mstall);
`endif
    endtask

    // One clock cycle: compare at the falling edge, drive inputs, advance the model, wait a cycle.
    task automatic applyStimulus(input bit iv, input logic [7:0] id, input bit orr, input bit ret);
        bit mPush, mPop;
        compareModel();
        i_v     = iv;
        i_d     = id;
        o_r     = orr;
        crd_ret = ret;
        mPush = iv && (mq.size() != 2);
        mPop  = orr && (mq.size() != 0) && (mcrd != 0);
        if ((mq.size() != 0) && (mcrd == 0) && (mstall != 32'hFFFF_FFFF)) begin
            mstall = mstall + 32'd1;
        end
        if (mPop) begin
            void'(mq.pop_front());
        end
        if (mPush) begin
            mq.push_back(id);
        end
        if (mPop && !ret) begin
            mcrd--;
        end else if (ret && !mPop) begin
            if (mcrd == Credits) begin
                merr = 1'b1;
            end else begin
                mcrd++;
            end
        end
        lastPop = mPop;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks that it takes effect without a clock.
    task automatic doReset();
        i_v     = 1'b0;
        o_r     = 1'b0;
        crd_ret = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_o_v", 32'(o_v), 32'd0);
        checkOutput("rst_i_r", 32'(i_r), 32'd1);
        checkOutput("rst_crd_avail", 32'(crd_avail), 32'd4);
        checkOutput("rst_crd_err", 32'(crd_err), 32'd0);
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
        checkOutput("rst_stall_cnt", o_stall_cnt, 32'd0);
`endif
        mq.delete();
        mcrd    = Credits;
        merr    = 1'b0;
        mstall  = 32'd0;
        lastPop = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        streamData[0] = 8'h11;
        streamData[1] = 8'h22;
        streamData[2] = 8'h33;
        streamData[3] = 8'h44;
        streamData[4] = 8'h55;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
        doReset();

        $display("[TB] streaming");
        obsq.delete();
        applyStimulus(1'b1, streamData[0], 1'b1, 1'b0);
        checkOutput("first_o_v", 32'(o_v), 32'd1);
        for (int k = 1; k < 5; k++) begin
            checkOutput("stream_i_r", 32'(i_r), 32'd1);
            applyStimulus(1'b1, streamData[k], 1'b1, lastPop);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, lastPop);
        checkOutput("stream_count", 32'(obsq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < obsq.size()) checkOutput("stream_order", 32'(obsq[k]), 32'(streamData[k]));
        end
        checkOutput("stream_crd", 32'(crd_avail), 32'd4);

        $display("[TB] credit exhaustion");
        doReset();
        obsq.delete();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 8'(8'hC0 + k), 1'b1, 1'b0);
        end
        checkOutput("exh_xfers", 32'(obsq.size()), 32'd4);
        checkOutput("exh_crd", 32'(crd_avail), 32'd0);
        checkOutput("exh_o_v", 32'(o_v), 32'd0);
        checkOutput("exh_i_r", 32'(i_r), 32'd0);
`ifdef BASE_CRDT_SLICE_STALL_CNT_EN
        stallBase = o_stall_cnt;
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stall_delta", o_stall_cnt - stallBase, 32'd10);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("exh_xfers_after_ret", 32'(obsq.size()), 32'd5);
        if (obsq.size() > 4) checkOutput("exh_fifth_beat", 32'(obsq[4]), 32'hC4);
        checkOutput("exh_crd_after_ret", 32'(crd_avail), 32'd0);

        $display("[TB] backpressure");
        doReset();
        obsq.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("bp_i_r", 32'(i_r), 32'd0);
        checkOutput("bp_o_v", 32'(o_v), 32'd1);
        checkOutput("bp_o_d", 32'(o_d), 32'hA5);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("bp_hold_o_v", 32'(o_v), 32'd1);
        checkOutput("bp_hold_o_d", 32'(o_d), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_i_r_rise", 32'(i_r), 32'd1);
        checkOutput("bp_second_o_d", 32'(o_d), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_xfers", 32'(obsq.size()), 32'd2);
        if (obsq.size() > 1) begin
            checkOutput("bp_first", 32'(obsq[0]), 32'hA5);
            checkOutput("bp_second", 32'(obsq[1]), 32'h5A);
        end
        checkOutput("bp_crd", 32'(crd_avail), 32'd2);

        $display("[TB] simultaneous consume/return and overflow");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("sim_crd", 32'(crd_avail), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("refill_crd", 32'(crd_avail), 32'd4);
        checkOutput("refill_err", 32'(crd_err), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_crd", 32'(crd_avail), 32'd4);
        checkOutput("ovf_err", 32'(crd_err), 32'd1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_err_sticky", 32'(crd_err), 32'd1);

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset();
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end
        compareModel();

        doReset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
